io_region_decoder: RTL and testbench

//  Parametrised, registered successor of the memory/IO address decoder: maps a request address onto
//  NUM_REGIONS one-hot peripheral selects (data memory, show, original, process buffers, ...).

---
 rtl/io_region_decoder_if.sv | 25 ++
 rtl/io_region_decoder.sv | 151 +++++++++++++++
 tb/tb_io_region_decoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/io_region_decoder_if.sv
// Request/select bus between a load/store requester and io_region_decoder.
// The requester uses the master modport, the decoder the slave modport.
interface io_region_decoder_if #(
    parameter int ADDR_W      = 24,
    parameter int NUM_REGIONS = 4
);
    logic                   req_valid;
    logic                   req_ready;
    logic [ADDR_W-1:0]      req_addr;
    logic                   req_we;
    logic [NUM_REGIONS-1:0] sel;
    logic                   sel_we;
    logic                   resp_valid;
    logic                   resp_err;

    modport master (
        output req_valid, req_addr, req_we,
        input  req_ready, sel, sel_we, resp_valid, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_we,
        output req_ready, sel, sel_we, resp_valid, resp_err
    );
endinterface

// File: rtl/io_region_decoder.sv
// Registered address decoder: one-hot region select with per-region wait states and an
// error response for unmapped addresses. Define IO_ERR_LATCH_EN to add the sticky error latch.
module io_region_decoder #(
    parameter int ADDR_W      = 24,
    parameter int NUM_REGIONS = 4,
    parameter int WAIT_W      = 4,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = {24'd130, 24'd120, 24'd100, 24'd0},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = {24'd140, 24'd129, 24'd116, 24'd96},
    parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT  = {4'd2, 4'd2, 4'd1, 4'd0}
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef IO_ERR_LATCH_EN
    input  logic              err_clr,
    output logic              err_sticky,
    output logic [ADDR_W-1:0] err_addr,
`endif
    io_region_decoder_if.slave bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e                 state_q, state_d;
    logic [NUM_REGIONS-1:0] sel_q, sel_d;
    logic                   sel_we_q, sel_we_d;
    logic [WAIT_W-1:0]      cnt_q, cnt_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_err_q, resp_err_d;

    logic                   hit;
    logic [NUM_REGIONS-1:0] hit_sel;
    logic [WAIT_W-1:0]      hit_wait;
    logic                   miss_xfer;

    // Offset compare: an address below BASE wraps to a large offset and fails the range test.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        hit      = 1'b0;
        hit_sel  = '0;
        hit_wait = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (!hit
                && (REGION_BASE[i*ADDR_W +: ADDR_W] <= REGION_LIMIT[i*ADDR_W +: ADDR_W])
                && ((bus.req_addr - REGION_BASE[i*ADDR_W +: ADDR_W])
                    <= (REGION_LIMIT[i*ADDR_W +: ADDR_W] - REGION_BASE[i*ADDR_W +: ADDR_W]))) begin
                hit        = 1'b1;
                hit_sel[i] = 1'b1;
                hit_wait   = REGION_WAIT[i*WAIT_W +: WAIT_W];
            end
        end
    end

    assign miss_xfer = (state_q == IDLE) && bus.req_valid && !hit;

    // NOTE: async reset clears every register; there is no storage array that could skip it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= '0;
            sel_we_q     <= 1'b0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            sel_q        <= sel_d;
            sel_we_q     <= sel_we_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sel_we_d     = sel_we_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (hit) begin
                        sel_d    = hit_sel;
                        sel_we_d = bus.req_we;
                        cnt_d    = hit_wait;
                        state_d  = ACCESS;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        state_d      = RESP;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end else begin
                    sel_d        = '0;
                    sel_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = (state_q == IDLE);
        bus.sel        = sel_q;
        bus.sel_we     = sel_we_q;
        bus.resp_valid = resp_valid_q;
        bus.resp_err   = resp_err_q;
    end

`ifdef IO_ERR_LATCH_EN
    logic              err_sticky_q, err_sticky_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    // A miss on the same edge as err_clr wins, so it is evaluated last.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        if (err_clr) err_sticky_d = 1'b0;
        if (miss_xfer) begin
            err_sticky_d = 1'b1;
            err_addr_d   = bus.req_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
        end
    end

    always_comb begin
        err_sticky = err_sticky_q;
        err_addr   = err_addr_q;
    end
`endif

endmodule

// File: tb/tb_io_region_decoder.sv
// Directed bench for io_region_decoder: table of single accesses plus hand sequences for
// reset abort, back-to-back/overlap and (with IO_ERR_LATCH_EN) the sticky error latch.
module tb_io_region_decoder;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    io_region_decoder_if #(.ADDR_W(24), .NUM_REGIONS(4)) bus_a ();
    io_region_decoder_if #(.ADDR_W(24), .NUM_REGIONS(4)) bus_b ();

`ifdef IO_ERR_LATCH_EN
    logic        err_clr_a, err_clr_b;
    logic        err_sticky_a, err_sticky_b;
    logic [23:0] err_addr_a, err_addr_b;
`endif

    io_region_decoder dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef IO_ERR_LATCH_EN
        .err_clr    (err_clr_a),
        .err_sticky (err_sticky_a),
        .err_addr   (err_addr_a),
`endif
        .bus        (bus_a)
    );

    // Region 1 starts at 90 (overlaps region 0); region 2 is disabled (limit < base).
    io_region_decoder #(
        .REGION_BASE  ({24'd130, 24'd129, 24'd90,  24'd0}),
        .REGION_LIMIT ({24'd140, 24'd120, 24'd116, 24'd96})
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef IO_ERR_LATCH_EN
        .err_clr    (err_clr_b),
        .err_sticky (err_sticky_b),
        .err_addr   (err_addr_b),
`endif
        .bus        (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] addr;
        logic        we;
        logic [3:0]  exp_sel;   // 0 means unmapped
        int          exp_wait;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one request on bus_a at a negedge and checks the full response timing.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        check({tag, " ready_before"}, 32'(bus_a.req_ready), 32'd1);
        bus_a.req_valid = 1'b1;
        bus_a.req_addr  = v.addr;
        bus_a.req_we    = v.we;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        bus_a.req_addr  = ~v.addr;
        bus_a.req_we    = ~v.we;
        if (v.exp_sel == 4'b0000) begin
            check({tag, " miss_resp_valid"}, 32'(bus_a.resp_valid), 32'd1);
            check({tag, " miss_resp_err"},   32'(bus_a.resp_err),   32'd1);
            check({tag, " miss_sel"},        32'(bus_a.sel),        32'd0);
            check({tag, " miss_ready"},      32'(bus_a.req_ready),  32'd0);
        end else begin
            for (int c = 0; c <= v.exp_wait; c++) begin
                check($sformatf("%s sel_c%0d", tag, c),    32'(bus_a.sel),        32'(v.exp_sel));
                check($sformatf("%s sel_we_c%0d", tag, c), 32'(bus_a.sel_we),     32'(v.we));
                check($sformatf("%s ready_c%0d", tag, c),  32'(bus_a.req_ready),  32'd0);
                check($sformatf("%s resp_c%0d", tag, c),   32'(bus_a.resp_valid), 32'd0);
                @(negedge clk);
            end
            check({tag, " hit_resp_valid"}, 32'(bus_a.resp_valid), 32'd1);
            check({tag, " hit_resp_err"},   32'(bus_a.resp_err),   32'd0);
            check({tag, " hit_sel_off"},    32'(bus_a.sel),        32'd0);
            check({tag, " hit_sel_we_off"}, 32'(bus_a.sel_we),     32'd0);
        end
        @(negedge clk);
        check({tag, " idle_resp_valid"}, 32'(bus_a.resp_valid), 32'd0);
        check({tag, " idle_resp_err"},   32'(bus_a.resp_err),   32'd0);
        check({tag, " idle_ready"},      32'(bus_a.req_ready),  32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{24'd50,  1'b1, 4'b0001, 0};
        vecs[1]  = '{24'd135, 1'b0, 4'b1000, 2};
        vecs[2]  = '{24'd96,  1'b1, 4'b0001, 0};
        vecs[3]  = '{24'd97,  1'b0, 4'b0000, 0};
        vecs[4]  = '{24'd100, 1'b1, 4'b0010, 1};
        vecs[5]  = '{24'd116, 1'b0, 4'b0010, 1};
        vecs[6]  = '{24'd117, 1'b1, 4'b0000, 0};
        vecs[7]  = '{24'd120, 1'b0, 4'b0100, 2};
        vecs[8]  = '{24'd129, 1'b1, 4'b0100, 2};
        vecs[9]  = '{24'd130, 1'b0, 4'b1000, 2};
        vecs[10] = '{24'd140, 1'b1, 4'b1000, 2};
        vecs[11] = '{24'd141, 1'b0, 4'b0000, 0};

        rst_n = 1'b1;
        bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.req_we = 1'b0;
        bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_we = 1'b0;
`ifdef IO_ERR_LATCH_EN
        err_clr_a = 1'b0;
        err_clr_b = 1'b0;
`endif
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset sel",        32'(bus_a.sel),        32'd0);
        check("reset sel_we",     32'(bus_a.sel_we),     32'd0);
        check("reset resp_valid", 32'(bus_a.resp_valid), 32'd0);
        check("reset resp_err",   32'(bus_a.resp_err),   32'd0);
`ifdef IO_ERR_LATCH_EN
        check("reset err_sticky", 32'(err_sticky_a), 32'd0);
        check("reset err_addr",   32'(err_addr_a),   32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("reset ready_after", 32'(bus_a.req_ready), 32'd1);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset during an access: select drops at once, no response appears.
        @(negedge clk);
        bus_a.req_valid = 1'b1; bus_a.req_addr = 24'd125; bus_a.req_we = 1'b1;
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        check("rst_mid sel_before", 32'(bus_a.sel), 32'b0100);
        rst_n = 1'b0;
        #1;
        check("rst_mid sel_now",    32'(bus_a.sel),        32'd0);
        check("rst_mid sel_we_now", 32'(bus_a.sel_we),     32'd0);
        check("rst_mid resp_now",   32'(bus_a.resp_valid), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst_mid resp_c%0d", c), 32'(bus_a.resp_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid ready_after", 32'(bus_a.req_ready),  32'd1);
        check("rst_mid resp_after",  32'(bus_a.resp_valid), 32'd0);
        check("rst_mid sel_after",   32'(bus_a.sel),        32'd0);

`ifdef IO_ERR_LATCH_EN
        run_vec('{24'd118, 1'b0, 4'b0000, 0}, "err118");
        check("err118 sticky", 32'(err_sticky_a), 32'd1);
        check("err118 addr",   32'(err_addr_a),   32'd118);
        @(negedge clk);
        err_clr_a = 1'b1;
        @(negedge clk);
        err_clr_a = 1'b0;
        check("err_clr sticky", 32'(err_sticky_a), 32'd0);
        check("err_clr addr",   32'(err_addr_a),   32'd118);
        @(negedge clk);
        err_clr_a = 1'b1;
        bus_a.req_valid = 1'b1; bus_a.req_addr = 24'd200; bus_a.req_we = 1'b0;
        @(negedge clk);
        err_clr_a = 1'b0;
        bus_a.req_valid = 1'b0;
        check("err_coinc sticky", 32'(err_sticky_a),       32'd1);
        check("err_coinc addr",   32'(err_addr_a),         32'd200);
        check("err_coinc resp",   32'(bus_a.resp_err),     32'd1);
        @(negedge clk);
        check("err_coinc idle",   32'(bus_a.req_ready),    32'd1);
`endif

        // Overlap plus back-to-back on dut_b with req_valid held high.
        @(negedge clk);
        bus_b.req_valid = 1'b1; bus_b.req_addr = 24'd95; bus_b.req_we = 1'b0;
        @(negedge clk);
        check("b2b sel1",   32'(bus_b.sel),        32'b0001);
        check("b2b ready1", 32'(bus_b.req_ready),  32'd0);
        @(negedge clk);
        check("b2b resp1",  32'(bus_b.resp_valid), 32'd1);
        check("b2b ready2", 32'(bus_b.req_ready),  32'd0);
        check("b2b sel2",   32'(bus_b.sel),        32'd0);
        @(negedge clk);
        check("b2b idle_ready", 32'(bus_b.req_ready),  32'd1);
        check("b2b idle_resp",  32'(bus_b.resp_valid), 32'd0);
        check("b2b idle_sel",   32'(bus_b.sel),        32'd0);
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        check("b2b sel_second", 32'(bus_b.sel), 32'b0001);
        @(negedge clk);
        check("b2b resp_second", 32'(bus_b.resp_valid), 32'd1);
        @(negedge clk);
        check("b2b idle_second", 32'(bus_b.req_ready), 32'd1);

        // Disabled region never hits.
        bus_b.req_valid = 1'b1; bus_b.req_addr = 24'd125;
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        check("disabled resp_valid", 32'(bus_b.resp_valid), 32'd1);
        check("disabled resp_err",   32'(bus_b.resp_err),   32'd1);
        check("disabled sel",        32'(bus_b.sel),        32'd0);
        @(negedge clk);
        check("disabled idle", 32'(bus_b.req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
